// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one single-port word memory between an instruction
//               fetch port (I, read-only) and a load/store port (D). At most
//               one access is granted per cycle. Each port has one registered
//               response slot that is held until the requester consumes it.
//               Misaligned or out-of-range accesses are accepted but flagged
//               with rerr=1, return rdata=0 and never write memory.
// Config      : ARB_ROUND_ROBIN_EN defined   -> ties go to the port not
//                                               granted most recently.
//               ARB_ROUND_ROBIN_EN undefined -> fixed priority, D wins ties.
// Ports       : clk, rst (async, active-high)
//               I port : i_req, i_addr, i_ready, i_rvalid, i_rready,
//                        i_rdata, i_rerr
//               D port : d_req, d_we, d_addr, d_wdata, d_ready, d_rvalid,
//                        d_rready, d_rdata, d_rerr
//               Memory : mem_addr, mem_we, mem_wdata, mem_rdata (comb. read)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 32
) (
    input  logic              clk,
    input  logic              rst,
    // Instruction-fetch port
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic              i_rvalid,
    input  logic              i_rready,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_rerr,
    // Load/store port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic              d_rvalid,
    input  logic              d_rready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rerr,
    // Memory side
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-3:0] c_DEPTH_WORDS = (ADDR_W-2)'(DEPTH_WORDS);

    // Response slots and memory address hold register
    logic              i_rvalid_q, i_rvalid_d;
    logic [DATA_W-1:0] i_rdata_q,  i_rdata_d;
    logic              i_rerr_q,   i_rerr_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0] d_rdata_q,  d_rdata_d;
    logic              d_rerr_q,   d_rerr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

    logic w_i_err, w_d_err;
    logic w_i_elig, w_d_elig;
    logic w_i_gnt, w_d_gnt;

    function automatic logic addr_err(input logic [ADDR_W-1:0] a);
        return (a[1:0] != 2'b00) || (a[ADDR_W-1:2] >= c_DEPTH_WORDS);
    endfunction

    assign w_i_err = addr_err(i_addr);
    assign w_d_err = addr_err(d_addr);

    // A port may be accepted when its response slot is free or is being
    // drained on this same edge.
    assign w_i_elig = i_req & (~i_rvalid_q | i_rready);
    assign w_d_elig = d_req & (~d_rvalid_q | d_rready);

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = D was granted most recently; reset value makes I win the first tie.
    logic last_grant_d_q, last_grant_d_d;

    // Grants are masked by rst so ready/mem_we drop as soon as reset asserts.
    assign w_i_gnt = ~rst & w_i_elig & (~w_d_elig |  last_grant_d_q);
    assign w_d_gnt = ~rst & w_d_elig & (~w_i_elig | ~last_grant_d_q);

    always_comb begin
        last_grant_d_d = last_grant_d_q;
        if (w_d_gnt) begin
            last_grant_d_d = 1'b1;
        end else if (w_i_gnt) begin
            last_grant_d_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_d_q <= 1'b1;
        end else begin
            last_grant_d_q <= last_grant_d_d;
        end
    end
`else
    // Fixed priority: D always wins a tie.
    assign w_d_gnt = ~rst & w_d_elig;
    assign w_i_gnt = ~rst & w_i_elig & ~w_d_elig;
`endif

    // Next-state for response slots and the memory address hold register
    always_comb begin
        i_rvalid_d = i_rvalid_q;
        i_rdata_d  = i_rdata_q;
        i_rerr_d   = i_rerr_q;
        d_rvalid_d = d_rvalid_q;
        d_rdata_d  = d_rdata_q;
        d_rerr_d   = d_rerr_q;
        mem_addr_d = mem_addr_q;

        // A new accept takes precedence over a drain, giving back-to-back
        // responses without a bubble.
        if (w_i_gnt) begin
            i_rvalid_d = 1'b1;
            i_rdata_d  = w_i_err ? '0 : mem_rdata;
            i_rerr_d   = w_i_err;
            mem_addr_d = i_addr;
        end else if (i_rvalid_q && i_rready) begin
            i_rvalid_d = 1'b0;
        end

        if (w_d_gnt) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = (w_d_err || d_we) ? '0 : mem_rdata;
            d_rerr_d   = w_d_err;
            mem_addr_d = d_addr;
        end else if (d_rvalid_q && d_rready) begin
            d_rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_rvalid_q <= 1'b0;
            i_rdata_q  <= '0;
            i_rerr_q   <= 1'b0;
            d_rvalid_q <= 1'b0;
            d_rdata_q  <= '0;
            d_rerr_q   <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            i_rvalid_q <= i_rvalid_d;
            i_rdata_q  <= i_rdata_d;
            i_rerr_q   <= i_rerr_d;
            d_rvalid_q <= d_rvalid_d;
            d_rdata_q  <= d_rdata_d;
            d_rerr_q   <= d_rerr_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // Outputs
    assign i_ready  = w_i_gnt;
    assign d_ready  = w_d_gnt;
    assign i_rvalid = i_rvalid_q;
    assign i_rdata  = i_rdata_q;
    assign i_rerr   = i_rerr_q;
    assign d_rvalid = d_rvalid_q;
    assign d_rdata  = d_rdata_q;
    assign d_rerr   = d_rerr_q;

    // Address follows the granted port combinationally so mem_rdata is valid
    // on the accepting edge; with no grant the last address is held.
    assign mem_addr  = w_i_gnt ? i_addr : (w_d_gnt ? d_addr : mem_addr_q);
    assign mem_we    = w_d_gnt & d_we & ~w_d_err;
    assign mem_wdata = rst ? '0 : d_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter, with a small
//               32-word memory model attached to the memory side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req, i_ready, i_rvalid, i_rready, i_rerr;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_ready, d_rvalid, d_rready, d_rerr;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    int passed = 0;
    int total  = 0;

    // Memory model: 32 words, combinational read, write on rising edge
    logic [31:0] mem [0:31] = '{3: 32'hDEADBEEF, default: 32'h0};
    int          we_count   = 0;
    logic        w_in_range;

    assign w_in_range = (mem_addr[31:7] == 25'd0);
    assign mem_rdata  = w_in_range ? mem[mem_addr[6:2]] : 32'h0;

    always @(posedge clk) begin
        if (mem_we) begin
            we_count <= we_count + 1;
            if (w_in_range) mem[mem_addr[6:2]] <= mem_wdata;
        end
    end

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ready   (i_ready),
        .i_rvalid  (i_rvalid),
        .i_rready  (i_rready),
        .i_rdata   (i_rdata),
        .i_rerr    (i_rerr),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ready   (d_ready),
        .d_rvalid  (d_rvalid),
        .d_rready  (d_rready),
        .d_rdata   (d_rdata),
        .d_rerr    (d_rerr),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Inputs change just after the falling edge; combinational outputs are
    // checked 1ns later, registered outputs 1ns after the rising edge.
    task automatic to_drive();
        @(negedge clk);
    endtask

    task automatic to_resp();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        i_req = 0; i_addr = 0; i_rready = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_rready = 0;

        // ---------------- Reset state ----------------
        to_drive();
        to_drive();
        #1;
        check("rst_i_ready",  {31'd0, i_ready},  32'd0);
        check("rst_d_ready",  {31'd0, d_ready},  32'd0);
        check("rst_i_rvalid", {31'd0, i_rvalid}, 32'd0);
        check("rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        check("rst_mem_we",   {31'd0, mem_we},   32'd0);
        check("rst_mem_addr", mem_addr,          32'd0);
        check("rst_i_rdata",  i_rdata,           32'd0);

        // ---------------- T1 single read ----------------
        to_drive();
        rst = 1'b0;
        i_req = 1; i_addr = 32'h0C;
        #1;
        check("t1_i_ready",  {31'd0, i_ready}, 32'd1);
        check("t1_mem_addr", mem_addr,         32'h0C);
        check("t1_mem_we",   {31'd0, mem_we},  32'd0);
        to_resp();
        check("t1_i_rvalid", {31'd0, i_rvalid}, 32'd1);
        check("t1_i_rdata",  i_rdata,           32'hDEADBEEF);
        check("t1_i_rerr",   {31'd0, i_rerr},   32'd0);
        to_drive();
        i_req = 0; i_rready = 1;
        #1;
        check("t1_addr_hold", mem_addr, 32'h0C);
        to_resp();
        check("t1_i_rvalid_clr", {31'd0, i_rvalid}, 32'd0);

        // ---------------- T2 write then read ----------------
        to_drive();
        d_req = 1; d_we = 1; d_addr = 32'h10; d_wdata = 32'h12345678; d_rready = 1;
        #1;
        check("t2_d_ready_w",  {31'd0, d_ready}, 32'd1);
        check("t2_mem_we",     {31'd0, mem_we},  32'd1);
        check("t2_mem_wdata",  mem_wdata,        32'h12345678);
        to_resp();
        check("t2_wr_rvalid",  {31'd0, d_rvalid}, 32'd1);
        check("t2_wr_rdata",   d_rdata,           32'd0);
        to_drive();
        d_we = 0;
        #1;
        check("t2_d_ready_r",  {31'd0, d_ready}, 32'd1);
        check("t2_mem_we_rd",  {31'd0, mem_we},  32'd0);
        to_resp();
        check("t2_rd_rdata",   d_rdata,           32'h12345678);
        check("t2_rd_rvalid",  {31'd0, d_rvalid}, 32'd1);
        to_drive();
        d_req = 0;
        to_resp();
        check("t2_d_rvalid_clr", {31'd0, d_rvalid}, 32'd0);
        check("t2_we_count",     we_count,          32'd1);

        // ---------------- T3 tie ----------------
        to_drive();
        i_req = 1; i_addr = 32'h0C; i_rready = 1;
        d_req = 1; d_we = 0; d_addr = 32'h10; d_rready = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
`ifdef ARB_ROUND_ROBIN_EN
            check($sformatf("t3_i_ready_%0d", k), {31'd0, i_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("t3_d_ready_%0d", k), {31'd0, d_ready}, (k % 2 == 0) ? 32'd0 : 32'd1);
`else
            check($sformatf("t3_i_ready_%0d", k), {31'd0, i_ready}, 32'd0);
            check($sformatf("t3_d_ready_%0d", k), {31'd0, d_ready}, 32'd1);
`endif
            to_drive();
        end
        i_req = 0; d_req = 0;
        to_resp();
        check("t3_i_rvalid_clr", {31'd0, i_rvalid}, 32'd0);
        check("t3_d_rvalid_clr", {31'd0, d_rvalid}, 32'd0);

        // ---------------- T4 backpressure ----------------
        to_drive();
        i_req = 1; i_addr = 32'h0C; i_rready = 0;
        #1;
        check("t4_first_ready", {31'd0, i_ready}, 32'd1);
        to_resp();
        check("t4_first_rdata", i_rdata, 32'hDEADBEEF);
        to_drive();
        i_addr = 32'h10;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("t4_stall_ready_%0d", k), {31'd0, i_ready}, 32'd0);
            to_resp();
            check($sformatf("t4_hold_rdata_%0d", k), i_rdata, 32'hDEADBEEF);
            check($sformatf("t4_hold_rvalid_%0d", k), {31'd0, i_rvalid}, 32'd1);
            to_drive();
        end
        i_rready = 1;
        #1;
        check("t4_release_ready", {31'd0, i_ready}, 32'd1);
        to_resp();
        check("t4_new_rvalid", {31'd0, i_rvalid}, 32'd1);
        check("t4_new_rdata",  i_rdata,           32'h12345678);
        to_drive();
        i_req = 0;
        to_resp();
        check("t4_rvalid_clr", {31'd0, i_rvalid}, 32'd0);

        // ---------------- T5 errors ----------------
        to_drive();
        d_req = 1; d_we = 1; d_addr = 32'h2; d_wdata = 32'hFFFFFFFF;
        #1;
        check("t5_d_ready",  {31'd0, d_ready}, 32'd1);
        check("t5_mem_we",   {31'd0, mem_we},  32'd0);
        to_resp();
        check("t5_d_rerr",   {31'd0, d_rerr},   32'd1);
        check("t5_d_rdata",  d_rdata,           32'd0);
        check("t5_d_rvalid", {31'd0, d_rvalid}, 32'd1);
        to_drive();
        d_req = 0;
        i_req = 1; i_addr = 32'h80;
        #1;
        check("t5_i_ready",  {31'd0, i_ready}, 32'd1);
        to_resp();
        check("t5_i_rerr",   {31'd0, i_rerr},  32'd1);
        check("t5_i_rdata",  i_rdata,          32'd0);
        check("t5_we_count", we_count,         32'd1);
        check("t5_mem0",     mem[0],           32'd0);
        to_drive();
        i_req = 0;
        to_resp();

        // ---------------- T6 reset mid-operation ----------------
        to_drive();
        d_req = 1; d_we = 0; d_addr = 32'h0C; d_rready = 0;
        to_resp();
        check("t6_pre_rvalid", {31'd0, d_rvalid}, 32'd1);
        to_drive();
        d_we = 1; d_addr = 32'h14; d_wdata = 32'hA5A5A5A5; d_rready = 1;
        #1;
        check("t6_pre_ready",  {31'd0, d_ready}, 32'd1);
        check("t6_pre_mem_we", {31'd0, mem_we},  32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("t6_rst_rvalid", {31'd0, d_rvalid}, 32'd0);
        check("t6_rst_ready",  {31'd0, d_ready},  32'd0);
        check("t6_rst_mem_we", {31'd0, mem_we},   32'd0);
        check("t6_rst_addr",   mem_addr,          32'd0);
        d_req = 0; d_we = 0;
        to_drive();
        rst = 1'b0;
        i_req = 1; i_addr = 32'h0C; i_rready = 1;
        d_req = 1; d_addr = 32'h10; d_rready = 1;
        #1;
`ifdef ARB_ROUND_ROBIN_EN
        check("t6_tie_i_ready", {31'd0, i_ready}, 32'd1);
        check("t6_tie_d_ready", {31'd0, d_ready}, 32'd0);
`else
        check("t6_tie_i_ready", {31'd0, i_ready}, 32'd0);
        check("t6_tie_d_ready", {31'd0, d_ready}, 32'd1);
`endif
        to_resp();
`ifdef ARB_ROUND_ROBIN_EN
        check("t6_after_rdata", i_rdata, 32'hDEADBEEF);
`else
        check("t6_after_rdata", d_rdata, 32'h12345678);
`endif
        check("t6_we_count", we_count, 32'd1);
        check("t6_mem5",     mem[5],   32'd0);
        to_drive();
        i_req = 0; d_req = 0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
